// File: rtl/branch_sequencer.sv
// Conditional branch resolution controller: borrows the shared ALU for the
// rs1-rs2 compare, evaluates the B-type condition and redirects fetch.
module branch_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       br_funct3_i,
  input  logic [XLEN-1:0]  br_pc_i,
  input  logic [12:0]      br_imm_i,
  input  logic [XLEN-1:0]  br_rs1_i,
  input  logic [XLEN-1:0]  br_rs2_i,
  output logic             alu_req_o,
  input  logic             alu_gnt_i,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  input  logic             alu_valid_i,
  input  logic             alu_zero_i,
  input  logic             alu_negative_i,
  input  logic             alu_borrow_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             resolve_valid_o,
  output logic             resolve_taken_o,
  output logic             resolve_exc_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] taken_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    ALU_REQ,
    ALU_WAIT,
    REDIRECT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [2:0]       funct3;
  logic [XLEN-1:0]  pc;
  logic [12:0]      imm;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic             taken, taken_next;
  logic             exc, exc_next;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  logic signed [XLEN-1:0] imm_ext;
  logic [XLEN-1:0]        target;
  logic                   accept;
  logic                   cond;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                       input logic negative, input logic borrow);
    logic c;
    case (f3)
      3'b000:  c = zero;
      3'b001:  c = !zero;
      3'b100:  c = negative;
      3'b101:  c = !negative;
      3'b110:  c = borrow;
      3'b111:  c = !borrow;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Target arithmetic wraps modulo 2^XLEN by construction of the adder width.
  assign imm_ext = {{(XLEN-13){imm[12]}}, imm};
  assign target  = pc + imm_ext;
  assign accept  = br_valid_i && (state == IDLE);
  assign cond    = branch_cond(funct3, alu_zero_i, alu_negative_i, alu_borrow_i);

  always_comb begin
    state_next = state;
    taken_next = taken;
    exc_next   = exc;
    case (state)
      IDLE: begin
        if (br_valid_i) begin
          taken_next = 1'b0;
          if (is_illegal(br_funct3_i)) begin
            exc_next   = 1'b1;
            state_next = DONE;
          end else begin
            exc_next   = 1'b0;
            state_next = ALU_REQ;
          end
        end
      end
      ALU_REQ: begin
        if (alu_gnt_i) state_next = ALU_WAIT;
      end
      ALU_WAIT: begin
        if (alu_valid_i) begin
          if (!cond) begin
            state_next = DONE;
          end else if (target[1:0] != 2'b00) begin
            exc_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          taken_next = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      taken        <= 1'b0;
      exc          <= 1'b0;
      funct3       <= '0;
      pc           <= '0;
      imm          <= '0;
      rs1          <= '0;
      rs2          <= '0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      state <= state_next;
      taken <= taken_next;
      exc   <= exc_next;
      if (accept) begin
        funct3 <= br_funct3_i;
        pc     <= br_pc_i;
        imm    <= br_imm_i;
        rs1    <= br_rs1_i;
        rs2    <= br_rs2_i;
      end
      if (state == DONE) begin
        if (!exc)  branch_count <= branch_count + CNT_W'(1);
        if (taken) taken_count  <= taken_count + CNT_W'(1);
      end
    end
  end

  assign br_ready_o       = (state == IDLE);
  assign alu_req_o        = (state == ALU_REQ);
  assign alu_a_o          = rs1;
  assign alu_b_o          = rs2;
  assign redirect_valid_o = (state == REDIRECT);
  assign redirect_pc_o    = (state == REDIRECT) ? target : '0;
  assign flush_o          = redirect_valid_o && redirect_ready_i;
  assign resolve_valid_o  = (state == DONE);
  assign resolve_taken_o  = (state == DONE) && taken;
  assign resolve_exc_o    = (state == DONE) && exc;
  assign branch_count_o   = branch_count;
  assign taken_count_o    = taken_count;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: an ALU model answers the compare,
// expected resolve results are queued at issue and compared on resolve_valid_o.
module tb_branch_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             br_valid = 1'b0;
  logic             br_ready;
  logic [2:0]       br_funct3 = '0;
  logic [XLEN-1:0]  br_pc = '0;
  logic [12:0]      br_imm = '0;
  logic [XLEN-1:0]  br_rs1 = '0;
  logic [XLEN-1:0]  br_rs2 = '0;
  logic             alu_req;
  logic             alu_gnt = 1'b0;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic             alu_valid = 1'b0;
  logic             alu_zero = 1'b0;
  logic             alu_negative = 1'b0;
  logic             alu_borrow = 1'b0;
  logic             redirect_valid;
  logic             redirect_ready = 1'b0;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             resolve_exc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  typedef struct packed {
    logic taken;
    logic exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] mdl_branch = '0;
  logic [CNT_W-1:0] mdl_taken  = '0;

  always #5 clk = ~clk;

  branch_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .br_valid_i(br_valid), .br_ready_o(br_ready), .br_funct3_i(br_funct3),
    .br_pc_i(br_pc), .br_imm_i(br_imm), .br_rs1_i(br_rs1), .br_rs2_i(br_rs2),
    .alu_req_o(alu_req), .alu_gnt_i(alu_gnt), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_valid_i(alu_valid), .alu_zero_i(alu_zero), .alu_negative_i(alu_negative),
    .alu_borrow_i(alu_borrow),
    .redirect_valid_o(redirect_valid), .redirect_ready_i(redirect_ready),
    .redirect_pc_o(redirect_pc), .flush_o(flush),
    .resolve_valid_o(resolve_valid), .resolve_taken_o(resolve_taken),
    .resolve_exc_o(resolve_exc),
    .branch_count_o(branch_count), .taken_count_o(taken_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one branch, plays the ALU and fetch roles with the given delays,
  // and checks every cycle until the resolve pulse.
  task automatic run_branch(input string name, input logic [2:0] f3,
                            input logic [31:0] pc, input logic [12:0] imm,
                            input logic [31:0] a, input logic [31:0] b,
                            input int gnt_dly, input int rdy_dly);
    logic zero, neg, bor, cond, ill, mis, exp_redir;
    logic [31:0] tgt;
    exp_t e, got;
    int lat, t, req_cyc, red_cyc, flush_cyc;
    bit done, valid_next;
    zero = (a == b);
    neg  = ($signed(a) < $signed(b));
    bor  = (a < b);
    case (f3)
      3'b000:  cond = zero;
      3'b001:  cond = !zero;
      3'b100:  cond = neg;
      3'b101:  cond = !neg;
      3'b110:  cond = bor;
      3'b111:  cond = !bor;
      default: cond = 1'b0;
    endcase
    ill = (f3 == 3'b010) || (f3 == 3'b011);
    tgt = pc + {{19{imm[12]}}, imm};
    mis = (tgt[1:0] != 2'b00);
    exp_redir = !ill && cond && !mis;
    e.taken = exp_redir;
    e.exc   = ill || (cond && mis);
    lat = ill ? 1 : (exp_redir ? 4 + gnt_dly + rdy_dly : 3 + gnt_dly);
    sb.push_back(e);
    if (!e.exc)  mdl_branch = mdl_branch + 1;
    if (e.taken) mdl_taken  = mdl_taken + 1;

    checks++;
    if (br_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: got %b want 1", name, br_ready);
    end
    br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm; br_rs1 = a; br_rs2 = b;
    step();
    br_valid = 1'b0;
    br_funct3 = $urandom; br_rs1 = $urandom; br_rs2 = $urandom; br_pc = $urandom;

    t = 1; done = 0; req_cyc = 0; red_cyc = 0; flush_cyc = 0; valid_next = 0;
    while (!done && t <= 40) begin
      alu_valid = valid_next;
      alu_zero = zero; alu_negative = neg; alu_borrow = bor;
      valid_next = 0;
      alu_gnt = 1'b0;
      if (alu_req) begin
        checks++;
        if (alu_a !== a || alu_b !== b) begin
          errors++;
          $display("FAIL %s alu_operands: got %h/%h want %h/%h", name, alu_a, alu_b, a, b);
        end
        if (req_cyc == gnt_dly) begin
          alu_gnt = 1'b1;
          valid_next = 1;
        end
        req_cyc++;
      end
      redirect_ready = 1'b0;
      if (redirect_valid) begin
        checks++;
        if (redirect_pc !== tgt) begin
          errors++;
          $display("FAIL %s redirect_pc: got %h want %h", name, redirect_pc, tgt);
        end
        redirect_ready = (red_cyc == rdy_dly);
        red_cyc++;
      end
      #1;
      if (flush) flush_cyc++;
      checks++;
      if (flush !== (redirect_valid && redirect_ready)) begin
        errors++;
        $display("FAIL %s flush_cycle%0d: got %b want %b", name, t, flush,
                 redirect_valid && redirect_ready);
      end
      checks++;
      if (br_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_ready_cycle%0d: got %b want 0", name, t, br_ready);
      end
      if (resolve_valid) begin
        done = 1;
        got.taken = resolve_taken;
        got.exc   = resolve_exc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard: got resolve pulse want none queued", name);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL %s resolve_taken_exc: got %b%b want %b%b", name,
                     got.taken, got.exc, e.taken, e.exc);
          end
        end
        checks++;
        if (t != lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, t, lat);
        end
      end else begin
        checks++;
        if (resolve_taken !== 1'b0 || resolve_exc !== 1'b0) begin
          errors++;
          $display("FAIL %s resolve_idle: got %b%b want 00", name, resolve_taken, resolve_exc);
        end
        step();
        t++;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got no resolve within 40 cycles want %0d", name, lat);
      sb.delete();
    end
    checks++;
    if (req_cyc != (ill ? 0 : gnt_dly + 1)) begin
      errors++;
      $display("FAIL %s alu_req_cycles: got %0d want %0d", name, req_cyc, ill ? 0 : gnt_dly + 1);
    end
    checks++;
    if (red_cyc != (exp_redir ? rdy_dly + 1 : 0) || flush_cyc != (exp_redir ? 1 : 0)) begin
      errors++;
      $display("FAIL %s redirect_flush_cycles: got %0d/%0d want %0d/%0d", name, red_cyc,
               flush_cyc, exp_redir ? rdy_dly + 1 : 0, exp_redir ? 1 : 0);
    end
    alu_valid = 1'b0; redirect_ready = 1'b0;
    step();
    checks++;
    if (br_ready !== 1'b1 || branch_count !== mdl_branch || taken_count !== mdl_taken) begin
      errors++;
      $display("FAIL %s post_counts: got rdy=%b %0d/%0d want rdy=1 %0d/%0d", name, br_ready,
               branch_count, taken_count, mdl_branch, mdl_taken);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (alu_req !== 0 || redirect_valid !== 0 || redirect_pc !== 0 || flush !== 0 ||
        resolve_valid !== 0 || resolve_taken !== 0 || resolve_exc !== 0 ||
        alu_a !== 0 || alu_b !== 0 || branch_count !== 0 || taken_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b rv=%b rpc=%h rs=%b cnt=%0d/%0d want all 0",
               alu_req, redirect_valid, redirect_pc, resolve_valid, branch_count, taken_count);
    end
    rst = 1'b0;
    step();
    checks++;
    if (br_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", br_ready);
    end
    mdl_branch = '0; mdl_taken = '0;
  endtask

  task automatic test_conditions();
    run_branch("beq_taken",   3'b000, 32'h100, 13'h010, 32'd5, 32'd5, 0, 0);
    run_branch("bne_not",     3'b001, 32'h300, 13'h040, 32'd7, 32'd7, 0, 0);
    run_branch("bltu_not",    3'b110, 32'h200, 13'h1FF8, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_branch("blt_taken",   3'b100, 32'h200, 13'h1FF8, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_branch("bgeu_taken",  3'b111, 32'h400, 13'h008, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_branch("bge_not",     3'b101, 32'h400, 13'h008, 32'hFFFF_FFFF, 32'd1, 0, 0);
  endtask

  task automatic test_exceptions();
    run_branch("illegal_010", 3'b010, 32'h100, 13'h010, 32'd1, 32'd1, 0, 0);
    run_branch("illegal_011", 3'b011, 32'h100, 13'h010, 32'd1, 32'd2, 0, 0);
    run_branch("misaligned",  3'b000, 32'h100, 13'h002, 32'd3, 32'd3, 0, 0);
  endtask

  task automatic test_stall();
    run_branch("stall_taken", 3'b001, 32'h800, 13'h0FC, 32'd1, 32'd2, 3, 4);
    run_branch("stall_not",   3'b000, 32'h800, 13'h0FC, 32'd1, 32'd2, 2, 0);
  endtask

  task automatic test_reset_mid();
    int n;
    br_valid = 1'b1; br_funct3 = 3'b000; br_pc = 32'hFFFF_FFF0; br_imm = 13'h0020;
    br_rs1 = 32'd9; br_rs2 = 32'd9;
    step();
    br_valid = 1'b0;
    alu_zero = 1'b1; alu_negative = 1'b0; alu_borrow = 1'b0;
    alu_gnt = 1'b1; alu_valid = 1'b1; redirect_ready = 1'b0;
    n = 0;
    while (!redirect_valid && n < 10) begin
      step();
      n++;
    end
    alu_gnt = 1'b0; alu_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10) begin
      errors++;
      $display("FAIL midreset_wrap_target: got v=%b pc=%h want v=1 pc=00000010",
               redirect_valid, redirect_pc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl_branch = '0; mdl_taken = '0;
    checks++;
    if (redirect_valid !== 0 || resolve_valid !== 0 || br_ready !== 1 || alu_a !== 0 ||
        branch_count !== 0 || taken_count !== 0) begin
      errors++;
      $display("FAIL midreset_state: got rv=%b res=%b rdy=%b a=%h cnt=%0d/%0d want 0 0 1 0 0/0",
               redirect_valid, resolve_valid, br_ready, alu_a, branch_count, taken_count);
    end
    redirect_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (resolve_valid !== 0 || flush !== 0 || branch_count !== 0) begin
        errors++;
        $display("FAIL midreset_quiet%0d: got res=%b flush=%b cnt=%0d want 0 0 0",
                 i, resolve_valid, flush, branch_count);
      end
    end
    redirect_ready = 1'b0;
    run_branch("wrap_taken", 3'b000, 32'hFFFF_FFF0, 13'h0020, 32'd9, 32'd9, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [12:0] imm;
    for (int i = 0; i < 10; i++) begin
      imm = 13'($urandom) & 13'h1FFE;
      run_branch("b2b", 3'($urandom), $urandom & 32'hFFFF_FFFC, imm,
                 32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
                 $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_conditions();
    test_exceptions();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
